rr_sel_mux: RTL and testbench

//  Parametrised successor to the fixed 3-input, 2-bit selector used in the tutorial examples.

---
 rtl/rr_sel_mux.sv | 102 ++++++++++
 tb/tb_rr_sel_mux.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rr_sel_mux.sv
// ============================================================================
// Module  : rr_sel_mux
// Brief   : N-channel round-robin / fixed-priority selector with a registered
//           valid/ready output stage carrying the granted channel index.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_sel_mux #(
  parameter int N  = 3,
  parameter int W  = 2,
  parameter int CW = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           fixed_pri,
  output logic [W-1:0]   out_data,
  output logic [CW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  logic [W-1:0]  w_ch_data [N];
  logic [CW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] chan_q, chan_d;
  logic          valid_q, valid_d;
  logic          w_gnt_vld;
  logic [CW-1:0] w_gnt_idx;
  logic          w_can_acc;
  logic          w_xfer;
  int            w_idx;

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign w_ch_data[i] = in_data[i*W +: W];
  end

  // Scan from the highest offset down so the last hit is the first in priority order.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (fixed_pri) begin
        w_idx = k;
      end else begin
        w_idx = int'(ptr_q) + k;
        if (w_idx >= N) w_idx = w_idx - N;
      end
      if (in_valid[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = CW'(w_idx);
      end
    end
  end

  assign w_can_acc = !valid_q || out_ready;
  assign in_ready  = (w_can_acc && w_gnt_vld && !rst)
                   ? ({{(N-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;
  assign w_xfer    = |(in_valid & in_ready);

  always_comb begin
    ptr_d   = ptr_q;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    if (w_xfer) begin
      data_d  = w_ch_data[w_gnt_idx];
      chan_d  = w_gnt_idx;
      valid_d = 1'b1;
      ptr_d   = (w_gnt_idx == C_LAST) ? '0 : w_gnt_idx + CW'(1);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_sel_mux.sv
// ============================================================================
// Module  : tb_rr_sel_mux
// Brief   : Directed self-checking bench for rr_sel_mux (N=3, W=2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rr_sel_mux;

  logic       clk;
  logic       rst;
  logic [5:0] in_data;
  logic [2:0] in_valid;
  logic [2:0] in_ready;
  logic       fixed_pri;
  logic [1:0] out_data;
  logic [1:0] out_chan;
  logic       out_valid;
  logic       out_ready;

  int chk_cnt;
  int pass_cnt;

  rr_sel_mux #(.N(3), .W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fixed_pri(fixed_pri),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 3'b111; in_data = 6'b00_11_01;
    fixed_pri = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (in_ready !== 3'b000) $display("FAIL rst_ready: got %b want 000", in_ready); else pass_cnt++;
    chk_cnt++; if (out_chan !== 2'd0) $display("FAIL rst_chan: got %0d want 0", out_chan); else pass_cnt++;
    chk_cnt++; if (out_data !== 2'd0) $display("FAIL rst_data: got %0d want 0", out_data); else pass_cnt++;
    rst = 1'b0;
    #1;
    chk_cnt++; if (in_ready !== 3'b001) $display("FAIL rel_ready: got %b want 001", in_ready); else pass_cnt++;
  endtask

  task automatic test_rr_fairness();
    logic [1:0] exp_d [3];
    exp_d[0] = 2'd1; exp_d[1] = 2'd3; exp_d[2] = 2'd0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL rr_valid[%0d]: got %b want 1", i, out_valid); else pass_cnt++;
      chk_cnt++; if (out_chan !== 2'(i % 3)) $display("FAIL rr_chan[%0d]: got %0d want %0d", i, out_chan, i % 3); else pass_cnt++;
      chk_cnt++; if (out_data !== exp_d[i % 3]) $display("FAIL rr_data[%0d]: got %0d want %0d", i, out_data, exp_d[i % 3]); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    out_ready = 1'b0;
    #1;
    chk_cnt++; if (in_ready !== 3'b000) $display("FAIL bp_ready0: got %b want 000", in_ready); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_cnt++; if (out_chan !== 2'd0) $display("FAIL bp_chan[%0d]: got %0d want 0", i, out_chan); else pass_cnt++;
      chk_cnt++; if (out_data !== 2'd1) $display("FAIL bp_data[%0d]: got %0d want 1", i, out_data); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); else pass_cnt++;
      chk_cnt++; if (in_ready !== 3'b000) $display("FAIL bp_ready[%0d]: got %b want 000", i, in_ready); else pass_cnt++;
    end
    out_ready = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 3'b010) $display("FAIL bp_rel_ready: got %b want 010", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (out_chan !== 2'd1) $display("FAIL bp_rel_chan: got %0d want 1", out_chan); else pass_cnt++;
    chk_cnt++; if (out_data !== 2'd3) $display("FAIL bp_rel_data: got %0d want 3", out_data); else pass_cnt++;
  endtask

  task automatic test_fixed();
    fixed_pri = 1'b1; in_valid = 3'b110;
    #1;
    chk_cnt++; if (in_ready !== 3'b010) $display("FAIL fx_ready: got %b want 010", in_ready); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_cnt++; if (out_chan !== 2'd1) $display("FAIL fx_chan[%0d]: got %0d want 1", i, out_chan); else pass_cnt++;
      chk_cnt++; if (out_data !== 2'd3) $display("FAIL fx_data[%0d]: got %0d want 3", i, out_data); else pass_cnt++;
    end
    fixed_pri = 1'b0;
    #1;
    chk_cnt++; if (in_ready !== 3'b100) $display("FAIL fx_rr_ready: got %b want 100", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (out_chan !== 2'd2) $display("FAIL fx_rr_chan: got %0d want 2", out_chan); else pass_cnt++;
    chk_cnt++; if (out_data !== 2'd0) $display("FAIL fx_rr_data: got %0d want 0", out_data); else pass_cnt++;
  endtask

  task automatic test_wrap_sparse();
    in_valid = 3'b010;
    @(posedge clk); #1;
    chk_cnt++; if (out_chan !== 2'd1) $display("FAIL ws_ch1: got %0d want 1", out_chan); else pass_cnt++;
    in_valid = 3'b100;
    #1;
    chk_cnt++; if (in_ready !== 3'b100) $display("FAIL ws_ready2: got %b want 100", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (out_chan !== 2'd2) $display("FAIL ws_ch2: got %0d want 2", out_chan); else pass_cnt++;
    in_valid = 3'b001;
    #1;
    chk_cnt++; if (in_ready !== 3'b001) $display("FAIL ws_ready0: got %b want 001", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (out_chan !== 2'd0) $display("FAIL ws_ch0: got %0d want 0", out_chan); else pass_cnt++;
    chk_cnt++; if (out_data !== 2'd1) $display("FAIL ws_d0: got %0d want 1", out_data); else pass_cnt++;
    in_valid = 3'b000;
    #1;
    chk_cnt++; if (in_ready !== 3'b000) $display("FAIL ws_ready_none: got %b want 000", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL ws_drop: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_chan !== 2'd0) $display("FAIL ws_hold_chan: got %0d want 0", out_chan); else pass_cnt++;
    chk_cnt++; if (out_data !== 2'd1) $display("FAIL ws_hold_data: got %0d want 1", out_data); else pass_cnt++;
    in_valid = 3'b111;
    #1;
    chk_cnt++; if (in_ready !== 3'b010) $display("FAIL ws_ptr1: got %b want 010", in_ready); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL ar_pre_valid: got %b want 1", out_valid); else pass_cnt++;
    chk_cnt++; if (out_chan !== 2'd1) $display("FAIL ar_pre_chan: got %0d want 1", out_chan); else pass_cnt++;
    #1;
    rst = 1'b1;
    #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL ar_valid: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (in_ready !== 3'b000) $display("FAIL ar_ready: got %b want 000", in_ready); else pass_cnt++;
    chk_cnt++; if (out_chan !== 2'd0) $display("FAIL ar_chan: got %0d want 0", out_chan); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_cnt++; if (in_ready !== 3'b001) $display("FAIL ar_rel_ready: got %b want 001", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (out_chan !== 2'd0) $display("FAIL ar_restart_chan: got %0d want 0", out_chan); else pass_cnt++;
    chk_cnt++; if (out_data !== 2'd1) $display("FAIL ar_restart_data: got %0d want 1", out_data); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL ar_restart_valid: got %b want 1", out_valid); else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    test_reset();
    test_rr_fairness();
    test_backpressure();
    test_fixed();
    test_wrap_sparse();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
